// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read / one-write register file with registered read data,
// optional write-to-read bypass, optional hard-wired zero at location 0,
// and a clear sweep that zeroes every location after reset.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clkout,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
  logic [WIDTH-1:0]  rd_data2_q, rd_data2_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              wr_ok;
  logic [WIDTH-1:0]  raw1, raw2;

  // Addresses at or above DEPTH map to no storage at all (no aliasing).
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Value a read port captures: out-of-range and the zero register read 0,
  // a colliding accepted write is forwarded only when BYPASS is set.
  function automatic logic [WIDTH-1:0] port_value(
    input logic [ADDR_W-1:0] a,
    input logic [WIDTH-1:0]  raw,
    input logic              wok,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    if (!in_range(a) || (ZERO_REG && a == '0)) return '0;
    if (BYPASS && wok && a == wa)              return wd;
    return raw;
  endfunction

  // Write qualification and raw array reads (array contents before this edge).
  always_comb begin
    wr_ok = wr_en && in_range(wr_addr) && !(ZERO_REG && wr_addr == '0);
    raw1  = in_range(rd_addr1) ? mem_q[rd_addr1] : '0;
    raw2  = in_range(rd_addr2) ? mem_q[rd_addr2] : '0;
  end

  // Next-state: clear sweep owns the write port while busy; READY serves accesses.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    unique case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_ptr_q;
        mem_wdata  = '0;
        rd_data1_d = '0;
        rd_data2_d = '0;
        if (clr_ptr_q == LAST) begin
          state_d   = READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      READY: begin
        mem_we = wr_ok;
        if (rd_en) begin
          rd_data1_d = port_value(rd_addr1, raw1, wr_ok, wr_addr, wr_data);
          rd_data2_d = port_value(rd_addr2, raw2, wr_ok, wr_addr, wr_data);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and read-data registers; rst overrides everything, even mid-sweep.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  // Storage array: single write port, no reset (the sweep zeroes it).
  always_ff @(posedge clkout) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: four configurations driven by the same stimulus,
// each checked every cycle against an array-based model, plus literal pins.
module tb_regfile_2r1w;

  logic        clkout = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd1 [4];
  logic [31:0] rd2 [4];
  logic        busy [4];

  always #5 clkout = ~clkout;

  // 0: defaults, 1: no bypass, 2: zero register, 3: DEPTH=20
  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b0)) u0 (
    .clkout(clkout), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(rd1[0]), .rd_data2(rd2[0]), .busy(busy[0]));
  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b0)) u1 (
    .clkout(clkout), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(rd1[1]), .rd_data2(rd2[1]), .busy(busy[1]));
  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) u2 (
    .clkout(clkout), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(rd1[2]), .rd_data2(rd2[2]), .busy(busy[2]));
  regfile_2r1w #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b0)) u3 (
    .clkout(clkout), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(rd1[3]), .rd_data2(rd2[3]), .busy(busy[3]));

  int checks = 0;
  int errors = 0;

  int cfg_depth [4] = '{32, 32, 32, 20};
  bit cfg_byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_zero  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [31:0] m_mem [4][32];
  logic [31:0] m_rd1 [4];
  logic [31:0] m_rd2 [4];
  bit          m_busy [4];
  int          m_cnt [4];
  bit          m_init = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_wok(input int k);
    return wr_en && int'(wr_addr) < cfg_depth[k] && !(cfg_zero[k] && wr_addr == 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
    if (int'(a) >= cfg_depth[k] || (cfg_zero[k] && a == 5'd0)) return 32'd0;
    if (cfg_byp[k] && m_wok(k) && a == wr_addr) return wr_data;
    return m_mem[k][a];
  endfunction

  // Model: busy lasts DEPTH edges after rst drops, then storage is all zero.
  always @(posedge clkout) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_init    = 1'b1;
        m_busy[k] = 1'b1;
        m_cnt[k]  = cfg_depth[k];
        m_rd1[k]  = 32'd0;
        m_rd2[k]  = 32'd0;
      end else if (m_busy[k]) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_busy[k] = 1'b0;
          for (int j = 0; j < 32; j++) m_mem[k][j] = 32'd0;
        end
      end else begin
        if (rd_en) begin
          m_rd1[k] = m_read(k, rd_addr1);
          m_rd2[k] = m_read(k, rd_addr2);
        end
        if (m_wok(k)) m_mem[k][wr_addr] = wr_data;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clkout) begin
    if (m_init) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_rd1[%0d]", k), rd1[k], m_rd1[k]);
        chk($sformatf("model_rd2[%0d]", k), rd2[k], m_rd2[k]);
        chk($sformatf("model_busy[%0d]", k), {31'd0, busy[k]}, {31'd0, m_busy[k]});
      end
    end
  end

  task automatic cyc(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clkout); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clkout); #1;
    rst = 1'b0;
  endtask

  // Pulse reset and measure how many sampled cycles busy stays high.
  task automatic reset_and_count(input string tag);
    int n0, n3, i;
    rst_pulse();
    chk({tag, "_rst_rd1"}, rd1[0], 32'd0);
    chk({tag, "_rst_rd2"}, rd2[0], 32'd0);
    chk({tag, "_rst_busy"}, {31'd0, busy[0]}, 32'd1);
    n0 = 1; n3 = 1;
    for (i = 0; i < 100; i++) begin
      @(posedge clkout); #1;
      if (busy[0]) n0++;
      if (busy[3]) n3++;
      if (!busy[0] && !busy[3]) break;
    end
    if (i == 100) begin
      errors++;
      $display("FAIL %s_busy_timeout: busy still high after 100 cycles", tag);
    end
    chk({tag, "_busy_len_d32"}, 32'(n0), 32'd32);
    chk({tag, "_busy_len_d20"}, 32'(n3), 32'd20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clkout);
    #1;

    // Reset sweep, then every location reads zero on both ports
    reset_and_count("sweep");
    for (int i = 0; i < 16; i++) cyc(1'b1, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0, 32'd0);
    chk("sweep_read_last", rd2[0], 32'd0);

    // Basic 2R1W and hold with rd_en=0
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h12345678);
    cyc(1'b1, 5'd5, 5'd9, 1'b0, 5'd0, 32'd0);
    chk("basic_rd1", rd1[0], 32'hDEADBEEF);
    chk("basic_rd2", rd2[0], 32'h12345678);
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
    chk("hold_rd1", rd1[0], 32'hDEADBEEF);
    chk("hold_rd2", rd2[0], 32'h12345678);

    // Collision on both ports at once
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11);
    cyc(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h22);
    chk("coll_byp_rd1", rd1[0], 32'h22);
    chk("coll_byp_rd2", rd2[0], 32'h22);
    chk("coll_old_rd1", rd1[1], 32'h11);
    chk("coll_old_rd2", rd2[1], 32'h11);
    cyc(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
    chk("coll_reread", rd1[1], 32'h22);

    // Zero register
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h00000101);
    cyc(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 32'd0);
    chk("zero_rd0", rd1[2], 32'd0);
    chk("zero_rd1", rd2[2], 32'h00000101);
    chk("nozero_rd0", rd1[0], 32'hFFFFFFFF);

    // Reset mid-operation; accesses during busy have no effect
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h55);
    cyc(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    chk("pre_rst_rd7", rd1[0], 32'h55);
    rst_pulse();
    for (int i = 0; i < 9; i++) cyc(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h77);
    chk("busy_access_rd", rd1[0], 32'd0);
    reset_and_count("midrst");
    cyc(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    chk("midrst_rd7_d0", rd1[0], 32'd0);
    chk("midrst_rd7_d1", rd2[1], 32'd0);

    // Out-of-range on DEPTH=20 (in range on DEPTH=32)
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd25, 32'hAA);
    cyc(1'b1, 5'd25, 5'd9, 1'b0, 5'd0, 32'd0);
    chk("oor_rd25", rd1[3], 32'd0);
    chk("oor_alias9", rd2[3], 32'd0);
    chk("inrange_rd25", rd1[0], 32'hAA);

    @(posedge clkout); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file with two read ports and one write port. Unlike the single-port array it replaces, it reads and writes in the same cycle. Additional features: optional write-to-read bypass, optional hard-wired zero register, and a reset-triggered clear sequencer that zeroes every location. It sits between instruction decode and the ALU, supplying both source operands and taking the writeback result each cycle.

## Interface

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of locations; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 5, address width in bits
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the read output
- ZERO_REG, 0, when 1 location 0 always reads 0 and ignores writes

Ports:
- clkout  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read strobe for both read ports
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rd_data1  out  WIDTH  registered read data, port 1
- rd_data2  out  WIDTH  registered read data, port 2
- busy  out  1  high while the clear sequencer runs; array inaccessible

## Operation

- States: CLEAR and READY.
- **Reset:**
  - Any edge with rst=1 forces state=CLEAR, clr_ptr=0, busy=1, rd_data1=rd_data2=0.
  - rst wins over all other inputs, including mid-sweep; the sweep restarts at address 0.
- **CLEAR:**
  - Each edge with rst=0 writes 0 to mem[clr_ptr] and increments clr_ptr.
  - On the edge that clears DEPTH-1, state becomes READY, busy becomes 0 and clr_ptr becomes 0.
  - rd_en and wr_en are ignored; rd_data1/2 hold 0.
- **READY, write:**
  - wr_en=1 writes wr_data to mem[wr_addr] at the edge.
  - Ignored if wr_addr ≥ DEPTH.
  - Ignored if ZERO_REG=1 and wr_addr=0.
- **READY, read:**
  - rd_en=1 loads rd_dataN from mem[rd_addrN] at the edge.
  - rd_en=0 holds rd_dataN unchanged.
  - rd_addrN ≥ DEPTH returns 0.
  - ZERO_REG=1 and rd_addrN=0 returns 0.
- **Read/write collision** (rd_en=1, wr_en=1, rd_addrN=wr_addr, write not ignored):
  - BYPASS=1: rd_dataN = wr_data (new value).
  - BYPASS=0: rd_dataN = previous contents (old value).
  - Both read ports may collide at once; each port applies the rule independently.
- Both read ports may address the same location; both return the same value.
- No internal width conversion; data is stored and returned bit-exact.

## Timing

- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N until the next rd_en edge.
- A write at edge N is visible to a non-bypassed read sampled at edge N+1.
- busy rises after the first rst=1 edge. It falls exactly DEPTH edges after rst is first sampled low (DEPTH=32: 32 cycles).
- The first legal access edge is the one after busy=0 is observed.
- Reset values: rd_data1=0, rd_data2=0, busy=1. All locations read 0 after the sweep.
- Single clock domain; no combinational path from inputs to outputs.

## Test plan

- **Reset sweep:** pulse rst for 1 cycle -> busy=1 for exactly 32 cycles after rst falls. Then reading addresses 0..31 (two per cycle) returns 0 on both ports.
- **Basic 2R1W:** write 0xDEADBEEF to addr 5 and 0x12345678 to addr 9. Then rd_addr1=5, rd_addr2=9 -> next cycle rd_data1=0xDEADBEEF, rd_data2=0x12345678. With rd_en=0 afterwards, both outputs hold.
- **Collision:** mem[3]=0x11. Same edge: wr_addr=3, wr_data=0x22, rd_addr1=rd_addr2=3 -> BYPASS=1: both ports 0x22. BYPASS=0: both ports 0x11, and a re-read next cycle gives 0x22.
- **ZERO_REG=1:** write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0. Writes to addr 1 are unaffected.
- **Out-of-range (DEPTH=20):** write 0xAA to addr 25 -> read addr 25 returns 0. Read addr 25 & 0xF (addr 9) shows no aliasing and still returns 0.
- **Reset mid-operation:** write 0x55 to addr 7, assert rst at cycle 10 of a sweep -> the sweep restarts (busy high 32 more cycles). addr 7 reads 0 afterwards. Accesses attempted while busy=1 have no effect.
